// File: rtl/lbp_scan_counter.sv
//------------------------------------------------------------------------------
// lbp_scan_counter
//   Raster-scan centre-pixel address generator for the LBP engine. Walks
//   every interior pixel of an IMG_W x IMG_H image, skipping MARGIN border
//   pixels on each side, with a start/busy/done frame handshake.
//   Optional macro LBP_SCAN_NEIGHBOR_EN: sequences the nine 3x3 window
//   addresses of every centre pixel (nb_idx/nb_addr ports).
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lbp_scan_counter #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int AW     = 7,
    parameter int MARGIN = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            en,
    output logic [AW-1:0]   x,
    output logic [AW-1:0]   y,
    output logic [2*AW-1:0] addr,
    output logic            valid,
    output logic            last,
    output logic            busy,
    output logic            done
`ifdef LBP_SCAN_NEIGHBOR_EN
    ,
    output logic [3:0]      nb_idx,
    output logic [2*AW-1:0] nb_addr
`endif
);

    localparam logic [AW-1:0] X_FIRST = AW'(MARGIN);
    localparam logic [AW-1:0] Y_FIRST = AW'(MARGIN);
    localparam logic [AW-1:0] X_LAST  = AW'(IMG_W - 1 - MARGIN);
    localparam logic [AW-1:0] Y_LAST  = AW'(IMG_H - 1 - MARGIN);
    localparam logic [AW-1:0] ONE     = AW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   x_q;
    logic [AW-1:0]   y_q;
    logic            busy_q;
    logic            done_q;
    logic [AW-1:0]   x_d;
    logic [AW-1:0]   y_d;
    logic            centre_last;
    logic            step_last;

`ifdef LBP_SCAN_NEIGHBOR_EN
    logic [3:0]      nb_q;
    logic [AW-1:0]   nb_x;
    logic [AW-1:0]   nb_y;
`endif

    // Next centre position in raster order; row wraps back to the left margin.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (x_q == X_LAST) begin
            x_d = X_FIRST;
            y_d = y_q + ONE;
        end else begin
            x_d = x_q + ONE;
        end
    end

    assign centre_last = (x_q == X_LAST) && (y_q == Y_LAST);

`ifdef LBP_SCAN_NEIGHBOR_EN
    assign step_last = centre_last && (nb_q == 4'd8);
`else
    assign step_last = centre_last;
`endif

    // Frame controller: IDLE/SCAN/DONE with registered position and flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= X_FIRST;
            y_q     <= Y_FIRST;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef LBP_SCAN_NEIGHBOR_EN
            nb_q    <= 4'd0;
`endif
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    // start wins over en here; the first step is not consumed
                    if (start) begin
                        state_q <= ST_SCAN;
                        x_q     <= X_FIRST;
                        y_q     <= Y_FIRST;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
`ifdef LBP_SCAN_NEIGHBOR_EN
                        nb_q    <= 4'd0;
`endif
                    end
                end
                ST_SCAN: begin
                    if (en) begin
                        if (step_last) begin
                            // final position is held for inspection in DONE
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
`ifdef LBP_SCAN_NEIGHBOR_EN
                            if (nb_q == 4'd8) begin
                                nb_q <= 4'd0;
                                x_q  <= x_d;
                                y_q  <= y_d;
                            end else begin
                                nb_q <= nb_q + 4'd1;
                            end
`else
                            x_q <= x_d;
                            y_q <= y_d;
`endif
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef LBP_SCAN_NEIGHBOR_EN
    // 3x3 window address; outside SCAN it rests on the (-1,-1) corner.
    always_comb begin
        nb_x = x_q - ONE;
        nb_y = y_q - ONE;
        if (busy_q) begin
            case (nb_q)
                4'd0:    begin nb_y = y_q;       nb_x = x_q;       end
                4'd1:    begin nb_y = y_q - ONE; nb_x = x_q - ONE; end
                4'd2:    begin nb_y = y_q - ONE; nb_x = x_q;       end
                4'd3:    begin nb_y = y_q - ONE; nb_x = x_q + ONE; end
                4'd4:    begin nb_y = y_q;       nb_x = x_q - ONE; end
                4'd5:    begin nb_y = y_q;       nb_x = x_q + ONE; end
                4'd6:    begin nb_y = y_q + ONE; nb_x = x_q - ONE; end
                4'd7:    begin nb_y = y_q + ONE; nb_x = x_q;       end
                default: begin nb_y = y_q + ONE; nb_x = x_q + ONE; end
            endcase
        end
    end

    assign nb_idx  = nb_q;
    assign nb_addr = {nb_y, nb_x};
`endif

    assign x     = x_q;
    assign y     = y_q;
    assign addr  = {y_q, x_q};
    assign valid = busy_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign last  = busy_q && step_last;

endmodule

`default_nettype wire

// File: tb/tb_lbp_scan_counter.sv
//------------------------------------------------------------------------------
// tb_lbp_scan_counter
//   Self-checking bench: an 8x8/MARGIN=1 instance and a default 128x128
//   instance driven with directed vectors and scan sequences.
//   Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lbp_scan_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // small instance: 8x8, AW=3, MARGIN=1
    logic       s_reset = 1'b0, s_start = 1'b0, s_en = 1'b0;
    logic [2:0] s_x, s_y;
    logic [5:0] s_addr;
    logic       s_valid, s_last, s_busy, s_done;
`ifdef LBP_SCAN_NEIGHBOR_EN
    logic [3:0] s_nb_idx;
    logic [5:0] s_nb_addr;
`endif

    lbp_scan_counter #(.IMG_W(8), .IMG_H(8), .AW(3), .MARGIN(1)) u_small (
        .clk   (clk),
        .reset (s_reset),
        .start (s_start),
        .en    (s_en),
        .x     (s_x),
        .y     (s_y),
        .addr  (s_addr),
        .valid (s_valid),
        .last  (s_last),
        .busy  (s_busy),
        .done  (s_done)
`ifdef LBP_SCAN_NEIGHBOR_EN
        ,
        .nb_idx  (s_nb_idx),
        .nb_addr (s_nb_addr)
`endif
    );

    // default instance: 128x128, AW=7, MARGIN=1
    logic        b_reset = 1'b0, b_start = 1'b0, b_en = 1'b0;
    logic [6:0]  b_x, b_y;
    logic [13:0] b_addr;
    logic        b_valid, b_last, b_busy, b_done;
`ifdef LBP_SCAN_NEIGHBOR_EN
    logic [3:0]  b_nb_idx;
    logic [13:0] b_nb_addr;
`endif

    lbp_scan_counter u_big (
        .clk   (clk),
        .reset (b_reset),
        .start (b_start),
        .en    (b_en),
        .x     (b_x),
        .y     (b_y),
        .addr  (b_addr),
        .valid (b_valid),
        .last  (b_last),
        .busy  (b_busy),
        .done  (b_done)
`ifdef LBP_SCAN_NEIGHBOR_EN
        ,
        .nb_idx  (b_nb_idx),
        .nb_addr (b_nb_addr)
`endif
    );

`ifdef LBP_SCAN_NEIGHBOR_EN
    localparam int SPC = 9;
`else
    localparam int SPC = 1;
`endif
    localparam int NS = 36 * SPC;

    int passed = 0;
    int total  = 0;

    logic [5:0] exp_addr [NS];
`ifdef LBP_SCAN_NEIGHBOR_EN
    logic [5:0] exp_nb   [NS];
    int         dy [9] = '{0, -1, -1, -1, 0, 0, 1, 1, 1};
    int         dx [9] = '{0, -1, 0, 1, -1, 1, -1, 0, 1};
`endif

    typedef struct {
        logic       rst;
        logic       st;
        logic       en;
        logic [2:0] ex;
        logic [2:0] ey;
        logic       ev;
        logic       el;
        logic       ed;
    } vec_t;

    vec_t vecs [11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic small_reset();
        s_reset = 1'b1; s_start = 1'b0; s_en = 1'b0;
        tick();
        s_reset = 1'b0;
    endtask

    task automatic small_start();
        s_start = 1'b1;
        tick();
        s_start = 1'b0;
    endtask

    // Walk a scan already showing step 0; returns number of en-qualified steps.
    task automatic scan_small(input bit rand_en, input int start_at, input int reset_at,
                              output int steps);
        int  k   = 0;
        int  cyc = 0;
        bit  e;
        while (s_valid && cyc < 2000 && k < NS) begin
            chk("scan_addr", 32'(s_addr), 32'(exp_addr[k]));
            chk("scan_last", 32'(s_last), 32'(k == NS - 1));
`ifdef LBP_SCAN_NEIGHBOR_EN
            chk("scan_nb_idx", 32'(s_nb_idx), 32'(k % 9));
            chk("scan_nb_addr", 32'(s_nb_addr), 32'(exp_nb[k]));
`endif
            if (k == reset_at) begin
                s_reset = 1'b1; s_en = 1'b1;
                tick();
                s_reset = 1'b0; s_en = 1'b0;
                steps = k;
                return;
            end
            e       = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
            s_en    = e;
            s_start = (k == start_at);
            tick();
            s_start = 1'b0;
            s_en    = 1'b0;
            if (e) k++;
            cyc++;
        end
        steps = k;
    endtask

    initial begin
        int steps;
        int k;

        // expected 8x8 scan, raster order over interior 1..6
        k = 0;
        for (int yy = 1; yy <= 6; yy++)
            for (int xx = 1; xx <= 6; xx++)
                for (int p = 0; p < SPC; p++) begin
                    exp_addr[k] = {3'(yy), 3'(xx)};
`ifdef LBP_SCAN_NEIGHBOR_EN
                    exp_nb[k] = {3'(yy + dy[p]), 3'(xx + dx[p])};
`endif
                    k++;
                end

`ifndef LBP_SCAN_NEIGHBOR_EN
        //           rst   st    en    x     y     v     l     d
        vecs = '{ '{1'b1, 1'b0, 1'b0, 3'd1, 3'd1, 1'b0, 1'b0, 1'b0},
                  '{1'b0, 1'b1, 1'b0, 3'd1, 3'd1, 1'b1, 1'b0, 1'b0},
                  '{1'b0, 1'b0, 1'b1, 3'd2, 3'd1, 1'b1, 1'b0, 1'b0},
                  '{1'b0, 1'b0, 1'b1, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0},
                  '{1'b0, 1'b0, 1'b0, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0},
                  '{1'b0, 1'b1, 1'b1, 3'd4, 3'd1, 1'b1, 1'b0, 1'b0},
                  '{1'b0, 1'b0, 1'b1, 3'd5, 3'd1, 1'b1, 1'b0, 1'b0},
                  '{1'b0, 1'b0, 1'b1, 3'd6, 3'd1, 1'b1, 1'b0, 1'b0},
                  '{1'b0, 1'b0, 1'b1, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0},
                  '{1'b0, 1'b0, 1'b0, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0},
                  '{1'b0, 1'b0, 1'b1, 3'd2, 3'd2, 1'b1, 1'b0, 1'b0} };
        for (int i = 0; i < 11; i++) begin
            s_reset = vecs[i].rst;
            s_start = vecs[i].st;
            s_en    = vecs[i].en;
            tick();
            chk("vec_x",     32'(s_x),     32'(vecs[i].ex));
            chk("vec_y",     32'(s_y),     32'(vecs[i].ey));
            chk("vec_valid", 32'(s_valid), 32'(vecs[i].ev));
            chk("vec_busy",  32'(s_busy),  32'(vecs[i].ev));
            chk("vec_last",  32'(s_last),  32'(vecs[i].el));
            chk("vec_done",  32'(s_done),  32'(vecs[i].ed));
        end
        s_start = 1'b0; s_en = 1'b0;
`endif

        // reset values
        small_reset();
        chk("rst_addr",  32'(s_addr),  32'o11);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_busy",  32'(s_busy),  32'd0);
        chk("rst_done",  32'(s_done),  32'd0);
        chk("rst_last",  32'(s_last),  32'd0);
`ifdef LBP_SCAN_NEIGHBOR_EN
        chk("rst_nb_idx",  32'(s_nb_idx),  32'd0);
        chk("rst_nb_addr", 32'(s_nb_addr), 32'o00);
`endif

        // continuous scan
        small_start();
        scan_small(1'b0, -1, -1, steps);
        chk("cont_steps", 32'(steps),   32'(NS));
        chk("cont_done",  32'(s_done),  32'd1);
        chk("cont_busy",  32'(s_busy),  32'd0);
        chk("cont_valid", 32'(s_valid), 32'd0);
        chk("cont_final", 32'(s_addr),  32'o66);

        // start with en in DONE: restart at (1,1), first step not consumed
        s_start = 1'b1; s_en = 1'b1;
        tick();
        s_start = 1'b0;
        chk("restart_valid", 32'(s_valid), 32'd1);
        chk("restart_done",  32'(s_done),  32'd0);
        chk("restart_addr",  32'(s_addr),  32'o11);
        tick();
        s_en = 1'b0;
        chk("restart_step1", 32'(s_addr),  32'(exp_addr[1]));

        // pseudo-random en
        small_reset();
        small_start();
        scan_small(1'b1, -1, -1, steps);
        chk("rand_steps", 32'(steps),  32'(NS));
        chk("rand_done",  32'(s_done), 32'd1);

        // start pulsed mid-scan is ignored
        small_reset();
        small_start();
        scan_small(1'b0, 10, -1, steps);
        chk("midstart_steps", 32'(steps),  32'(NS));
        chk("midstart_done",  32'(s_done), 32'd1);

        // reset mid-scan, then a fresh scan
        small_reset();
        small_start();
        scan_small(1'b0, -1, 20, steps);
        chk("midrst_busy",  32'(s_busy),  32'd0);
        chk("midrst_done",  32'(s_done),  32'd0);
        chk("midrst_valid", 32'(s_valid), 32'd0);
        chk("midrst_addr",  32'(s_addr),  32'o11);
        small_start();
        scan_small(1'b0, -1, -1, steps);
        chk("rescan_steps", 32'(steps),  32'(NS));
        chk("rescan_done",  32'(s_done), 32'd1);

`ifndef LBP_SCAN_NEIGHBOR_EN
        // full default-size frame
        begin
            int          cnt      = 0;
            int          early    = 0;
            logic [13:0] last_a   = '0;
            logic        last_f   = 1'b0;
            b_reset = 1'b1;
            tick();
            b_reset = 1'b0;
            b_start = 1'b1; b_en = 1'b1;
            tick();
            b_start = 1'b0;
            chk("big_first_addr", 32'(b_addr), 32'h0081);
            while (b_valid && cnt < 20000) begin
                last_a = b_addr;
                last_f = b_last;
                if (b_last && cnt != 15875) early++;
                cnt++;
                tick();
            end
            b_en = 1'b0;
            chk("big_count",     32'(cnt),    32'd15876);
            chk("big_last_addr", 32'(last_a), 32'h3F7E);
            chk("big_last_flag", 32'(last_f), 32'd1);
            chk("big_early_last", 32'(early), 32'd0);
            chk("big_done",      32'(b_done), 32'd1);
        end
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
